// File: rtl/shift_pkg.sv
// Shared encodings for the proc2 shift/rotate unit: Mode values and FSM states.
// Used by shift_step and shift_unit_seq (build option SHIFT_UNIT_BARREL_EN lives in those files).
package shift_pkg;

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  // Encodings above ROL move the operand through untouched.
  function automatic logic is_pass_mode(input logic [2:0] mode);
    return mode > MODE_ROL;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift datapath: one 1-bit step when amount_i != 0, or, with
// SHIFT_UNIT_BARREL_EN defined, the full amount_i-bit shift in one pass.
module shift_step
  import shift_pkg::*;
#(
  parameter int W   = 16,
  parameter int SHW = 4
) (
  input  logic [W-1:0]   acc_i,
  input  logic [2:0]     mode_i,
  input  logic [SHW-1:0] amount_i,
  output logic [W-1:0]   acc_o,
  output logic           carry_o
);

  // Returns {bit moved out, next operand} for a single-position move.
  function automatic logic [W:0] step1(input logic [W-1:0] a, input logic [2:0] m);
    logic [W:0] r;
    case (m)
      MODE_LSL: r = {a[W-1], a[W-2:0], 1'b0};
      MODE_LSR: r = {a[0], 1'b0, a[W-1:1]};
      MODE_ASR: r = {a[0], a[W-1], a[W-1:1]};
      MODE_ROR: r = {a[0], a[0], a[W-1:1]};
      MODE_ROL: r = {a[W-1], a[W-2:0], a[W-1]};
      default:  r = {1'b0, a};
    endcase
    return r;
  endfunction

  logic [W:0] res;

`ifdef SHIFT_UNIT_BARREL_EN
  always_comb begin
    res = {1'b0, acc_i};
    for (int i = 0; i < W; i++) begin
      if (SHW'(i) < amount_i) res = step1(res[W-1:0], mode_i);
    end
  end
`else
  always_comb begin
    res = {1'b0, acc_i};
    if (amount_i != '0) res = step1(acc_i, mode_i);
  end
`endif

  assign acc_o   = res[W-1:0];
  assign carry_o = res[W];

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shift/rotate unit: IDLE -> SHIFT -> DONE handshake with Busy/Done.
// SHIFT_UNIT_BARREL_EN selects a fixed two-edge barrel form instead of 1 bit/edge.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int W   = 16,
  parameter int SHW = 4
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           Run,
  input  logic [2:0]     Mode,
  input  logic [W-1:0]   Din,
  input  logic [SHW-1:0] Shamt,
  output logic           Busy,
  output logic           Done,
  output logic [W-1:0]   Dout,
  output logic           Carry,
  output logic           Zero,
  output shift_state_e   dbg_state
);

  // Handshake: Run is accepted only in IDLE; Busy covers SHIFT and DONE, Done is a
  // single-cycle pulse, and Dout/Carry/Zero change only on DONE entry or reset.

  shift_state_e   state_q, state_d;
  logic [2:0]     mode_q, mode_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic           cr_q, cr_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           carry_q, carry_d;
  logic           zero_q, zero_d;
`ifdef SHIFT_UNIT_BARREL_EN
  logic           stepped_q, stepped_d;
`endif

  logic [W-1:0]   step_acc;
  logic           step_carry;

  shift_step #(.W(W), .SHW(SHW)) u_step (
    .acc_i   (acc_q),
    .mode_i  (mode_q),
    .amount_i(cnt_q),
    .acc_o   (step_acc),
    .carry_o (step_carry)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    cr_d    = cr_q;
    dout_d  = dout_q;
    carry_d = carry_q;
    zero_d  = zero_q;
`ifdef SHIFT_UNIT_BARREL_EN
    stepped_d = stepped_q;
`endif
    case (state_q)
      IDLE: begin
        if (Run) begin
          mode_d  = Mode;
          acc_d   = Din;
          cnt_d   = is_pass_mode(Mode) ? '0 : Shamt;
          cr_d    = 1'b0;
          state_d = SHIFT;
`ifdef SHIFT_UNIT_BARREL_EN
          stepped_d = 1'b0;
`endif
        end
      end
      SHIFT: begin
`ifdef SHIFT_UNIT_BARREL_EN
        if (!stepped_q) begin
          acc_d     = step_acc;
          cr_d      = step_carry;
          stepped_d = 1'b1;
        end else begin
          dout_d  = acc_q;
          carry_d = cr_q;
          zero_d  = (acc_q == '0);
          state_d = DONE;
        end
`else
        if (cnt_q != '0) begin
          acc_d = step_acc;
          cr_d  = step_carry;
          cnt_d = cnt_q - SHW'(1);
        end else begin
          dout_d  = acc_q;
          carry_d = cr_q;
          zero_d  = (acc_q == '0);
          state_d = DONE;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      mode_q  <= MODE_LSL;
      acc_q   <= '0;
      cnt_q   <= '0;
      cr_q    <= 1'b0;
      dout_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`ifdef SHIFT_UNIT_BARREL_EN
      stepped_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      cr_q    <= cr_d;
      dout_q  <= dout_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
`ifdef SHIFT_UNIT_BARREL_EN
      stepped_q <= stepped_d;
`endif
    end
  end

  assign Busy      = (state_q != IDLE);
  assign Done      = (state_q == DONE);
  assign Dout      = dout_q;
  assign Carry     = carry_q;
  assign Zero      = zero_q;
  assign dbg_state = state_q;

endmodule
